rle_block_builder: RTL

//  Run-length expander between the Huffman symbol decoder and unzigzag.

---
 rtl/jpeg_pkg.sv | 28 ++
 rtl/dc_predictor.sv | 49 ++++
 rtl/rle_block_builder.sv | 119 +++++++++++
 3 files changed

// File: rtl/jpeg_pkg.sv
// Shared JPEG decode-path types and constants.
//   coef_t      : signed coefficient, `Q bits
//   comp_t      : colour component id for the default three-component build
//   rbb_state_e : block builder FSM states
//   ZRL_RUN     : run code that, with value 0, stands for sixteen zeros
`ifndef Q
`define Q 16
`endif
`ifndef BLOCK_BUFF_SIZE
`define BLOCK_BUFF_SIZE 64
`endif

package jpeg_pkg;
  localparam int unsigned COEF_W       = `Q;
  localparam int unsigned LINE_LEN     = `BLOCK_BUFF_SIZE;
  localparam int unsigned NUM_COMP_DEF = 3;
  localparam int unsigned COMP_W       = $clog2(NUM_COMP_DEF);

  typedef logic signed [COEF_W-1:0] coef_t;
  typedef logic [COMP_W-1:0]        comp_t;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } rbb_state_e;

  localparam logic [3:0] ZRL_RUN = 4'd15;
endpackage

// File: rtl/dc_predictor.sv
// Per-component DC predictors with a read-add-write port.
//   clock, reset : clock, synchronous active-high reset
//   clr          : restart marker, zeroes every predictor (wins over upd)
//   upd          : store sum into the predictor selected by comp
//   comp         : component select
//   diff         : DC difference to add
//   sum          : predictor[comp] + diff, wraps at COEF_W bits
`ifndef Q
`define Q 16
`endif

module dc_predictor
  import jpeg_pkg::*;
#(
  parameter int unsigned NUM_COMP = 3
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        clr,
  input  logic                        upd,
  input  logic [$clog2(NUM_COMP)-1:0] comp,
  input  coef_t                       diff,
  output coef_t                       sum
);

  coef_t r_pred [NUM_COMP];
  coef_t w_cur;

  // Out-of-range ids read as zero rather than X.
  always_comb begin
    w_cur = '0;
    for (int unsigned i = 0; i < NUM_COMP; i++) begin
      if (32'(comp) == i) w_cur = r_pred[i];
    end
  end

  assign sum = w_cur + diff;

  always_ff @(posedge clock) begin
    if (reset || clr) begin
      for (int unsigned i = 0; i < NUM_COMP; i++) r_pred[i] <= '0;
    end else if (upd) begin
      for (int unsigned i = 0; i < NUM_COMP; i++) begin
        if (32'(comp) == i) r_pred[i] <= sum;
      end
    end
  end

endmodule

// File: rtl/rle_block_builder.sv
// Run-length expander: turns (run, value) symbols into a 64-entry zigzag line.
//   clock, reset          : clock, synchronous active-high reset
//   sym_valid/sym_ready   : symbol handshake
//   sym_eob               : end of block (run/value ignored)
//   sym_run, sym_value    : zeros before value, signed value (DC diff on first)
//   sym_comp              : component, sampled on the DC symbol
//   dc_reset              : restart marker, clears DC predictors
//   line_valid/line_ready : completed-block handshake
//   line, line_comp       : coefficients (index 0 = DC) and their component
//   err_ovf               : sticky run overflow / EOB-as-DC flag
`ifndef Q
`define Q 16
`endif
`ifndef BLOCK_BUFF_SIZE
`define BLOCK_BUFF_SIZE 64
`endif

module rle_block_builder
  import jpeg_pkg::*;
#(
  parameter int unsigned NUM_COMP = 3
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  sym_valid,
  output logic                                  sym_ready,
  input  logic                                  sym_eob,
  input  logic [3:0]                            sym_run,
  input  logic [`Q-1:0]                         sym_value,
  input  logic [$clog2(NUM_COMP)-1:0]           sym_comp,
  input  logic                                  dc_reset,
  output logic                                  line_valid,
  input  logic                                  line_ready,
  output logic [`BLOCK_BUFF_SIZE-1:0][`Q-1:0]   line,
  output logic [$clog2(NUM_COMP)-1:0]           line_comp,
  output logic                                  err_ovf
);

  rbb_state_e r_state, w_next;
  logic [6:0] r_idx;
  logic [`BLOCK_BUFF_SIZE-1:0][`Q-1:0] r_line;
  logic [$clog2(NUM_COMP)-1:0] r_line_comp;
  logic r_err;

  logic  w_accept, w_dc, w_ovf, w_last, w_done;
  logic [6:0] w_pos;
  coef_t w_dc_sum;

  assign w_accept = sym_valid && (r_state == FILL);
  assign w_dc     = (r_idx == 7'd0);
  assign w_pos    = r_idx + {3'b000, sym_run};
  assign w_ovf    = (w_pos > 7'd63);
  assign w_last   = (w_pos == 7'd63);
  // A block ends on EOB, on overflow, or once position 63 has been written.
  assign w_done   = sym_eob || (!w_dc && (w_ovf || w_last));

  dc_predictor #(.NUM_COMP(NUM_COMP)) u_pred (
    .clock (clock),
    .reset (reset),
    .clr   (dc_reset),
    .upd   (w_accept && w_dc && !sym_eob),
    .comp  (sym_comp),
    .diff  (coef_t'(sym_value)),
    .sum   (w_dc_sum)
  );

  always_ff @(posedge clock) begin
    if (reset) r_state <= FILL;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    sym_ready  = 1'b0;
    line_valid = 1'b0;
    case (r_state)
      FILL: begin
        sym_ready = 1'b1;
        if (w_accept && w_done) w_next = HOLD;
      end
      HOLD: begin
        line_valid = 1'b1;
        if (line_ready) w_next = FILL;
      end
      default: w_next = FILL;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_idx       <= '0;
      r_line      <= '0;
      r_line_comp <= '0;
      r_err       <= 1'b0;
    end else if (w_accept) begin
      if (sym_eob) begin
        if (w_dc) r_err <= 1'b1;
      end else if (w_dc) begin
        r_line[0]   <= w_dc_sum;
        r_line_comp <= sym_comp;
        r_idx       <= 7'd1;
      end else if (w_ovf) begin
        r_err <= 1'b1;
      end else begin
        r_line[w_pos[5:0]] <= sym_value;
        r_idx              <= w_pos + 7'd1;
      end
    end else if ((r_state == HOLD) && line_ready) begin
      // Clearing on hand-off means the next block starts zero-filled.
      r_line <= '0;
      r_idx  <= '0;
    end
  end

  assign line      = r_line;
  assign line_comp = r_line_comp;
  assign err_ovf   = r_err;

endmodule
